// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage of the pipelined CPU.
// One request at a time, fixed wait states, one-cycle MemReady pulse.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   input  logic [3:0]  ByteEn,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemError,
   output logic        Stall
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam bit NO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0] CNT_LOAD =
      NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   logic [1:0]            state;
   logic [3:0]            cnt;
   logic                  lat_rd;
   logic [ADDR_WIDTH-1:0] lat_idx;
   logic [31:0]           lat_wdata;
   logic [3:0]            lat_be;

   logic [31:0] mem [DEPTH];

   logic                  req;
   logic                  req_err;
   logic [ADDR_WIDTH-1:0] in_idx;
   logic                  acc_en;
   logic                  acc_rd;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic [31:0]           acc_wdata;
   logic [3:0]            acc_be;

   // Request decode and selection of the access performed this edge
   always_comb begin
      req     = MemRead | MemWrite;
      req_err = (MemRead & MemWrite)
              | (Addr[1:0] != 2'b00)
              | ((Addr >> (ADDR_WIDTH + 2)) != 32'd0);
      in_idx    = Addr[ADDR_WIDTH+1:2];
      acc_en    = 1'b0;
      acc_rd    = 1'b0;
      acc_idx   = '0;
      acc_wdata = '0;
      acc_be    = '0;
      if (state == IDLE && req && !req_err && NO_WAIT) begin
         acc_en    = reset;
         acc_rd    = MemRead;
         acc_idx   = in_idx;
         acc_wdata = WriteData;
         acc_be    = ByteEn;
      end else if (state == WAIT && cnt == 4'd0) begin
         acc_en    = reset;
         acc_rd    = lat_rd;
         acc_idx   = lat_idx;
         acc_wdata = lat_wdata;
         acc_be    = lat_be;
      end
   end

   // Pipeline hold while a request has not yet been answered
   always_comb begin
      Stall = req & ~MemReady;
   end

   // Byte-enabled array write; contents survive reset
   always_ff @(posedge clock) begin
      if (acc_en && !acc_rd) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b])
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   // Control FSM, request latch and registered response
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_rd    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         ReadData  <= '0;
         MemReady  <= 1'b0;
         MemError  <= 1'b0;
      end else begin
         MemReady <= 1'b0;
         MemError <= 1'b0;
         if (acc_en && acc_rd)
            ReadData <= mem[acc_idx];
         unique case (state)
            IDLE: begin
               if (req) begin
                  lat_rd    <= MemRead;
                  lat_idx   <= in_idx;
                  lat_wdata <= WriteData;
                  lat_be    <= ByteEn;
                  if (req_err) begin
                     state    <= RESP;
                     MemReady <= 1'b1;
                     MemError <= 1'b1;
                     ReadData <= '0;
                  end else if (NO_WAIT) begin
                     state    <= RESP;
                     MemReady <= 1'b1;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state    <= RESP;
                  MemReady <= 1'b1;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Covers wait states, merge, errors, zero-wait, reset and drop.
module tb_dmem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        rd, wr;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic [31:0] ReadData;
   logic        MemReady, MemError, Stall;

   logic        rd0, wr0;
   logic [31:0] addr0, wdata0;
   logic [3:0]  be0;
   logic [31:0] ReadData0;
   logic        MemReady0, MemError0, Stall0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
      .clock(clock), .reset(reset),
      .MemRead(rd), .MemWrite(wr), .Addr(addr),
      .WriteData(wdata), .ByteEn(be),
      .ReadData(ReadData), .MemReady(MemReady),
      .MemError(MemError), .Stall(Stall)
   );

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
      .clock(clock), .reset(reset),
      .MemRead(rd0), .MemWrite(wr0), .Addr(addr0),
      .WriteData(wdata0), .ByteEn(be0),
      .ReadData(ReadData0), .MemReady(MemReady0),
      .MemError(MemError0), .Stall(Stall0)
   );

   // Drives one request starting at a negedge; lat=99 means no response
   task automatic run_req(
      input  logic        r, w,
      input  logic [31:0] a, d,
      input  logic [3:0]  b,
      input  int          drop_at,
      output int          lat,
      output logic [3:0]  st,
      output logic        er,
      output logic [31:0] rdat
   );
      st = '0; er = 1'b0; rdat = '0; lat = 99;
      rd = r; wr = w; addr = a; wdata = d; be = b;
      #1;
      st[0] = Stall;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k == drop_at) begin
            rd = 1'b0; wr = 1'b0;
            #1;
         end
         if (k < 4) st[k[1:0]] = Stall;
         if (MemReady) begin
            lat = k; er = MemError; rdat = ReadData;
            break;
         end
      end
      rd = 1'b0; wr = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      rd = 0; wr = 0; addr = 0; wdata = 0; be = 0;
      rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
      #12;
      checks++;
      if ({ReadData, MemReady, MemError, Stall} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outs got %h want 0",
                  {ReadData, MemReady, MemError, Stall});
      end
      checks++;
      if ({ReadData0, MemReady0, MemError0, Stall0} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outs0 got %h want 0",
                  {ReadData0, MemReady0, MemError0, Stall0});
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_write_read;
      int lat; logic [3:0] st; logic er; logic [31:0] rv;
      run_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 3 || er !== 1'b0) begin
         errors++;
         $display("FAIL wr_lat got %0d/%b want 3/0", lat, er);
      end
      checks++;
      if (st !== 4'b0111) begin
         errors++;
         $display("FAIL wr_stall got %b want 0111", st);
      end
      run_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 3 || rv !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_data got %0d/%h want 3/deadbeef", lat, rv);
      end
      checks++;
      if (st !== 4'b0111) begin
         errors++;
         $display("FAIL rd_stall got %b want 0111", st);
      end
   endtask

   task automatic test_byte_merge;
      int lat; logic [3:0] st; logic er; logic [31:0] rv;
      run_req(1'b0, 1'b1, 32'h30, 32'h11223344, 4'hF, 0,
              lat, st, er, rv);
      run_req(1'b0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 0,
              lat, st, er, rv);
      checks++;
      if (ReadData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_hold got %h want deadbeef", ReadData);
      end
      run_req(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 3 || er !== 1'b0) begin
         errors++;
         $display("FAIL be0_lat got %0d/%b want 3/0", lat, er);
      end
      run_req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (rv !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL merge got %h want 11bb33dd", rv);
      end
   endtask

   task automatic test_errors;
      int lat; logic [3:0] st; logic er; logic [31:0] rv;
      run_req(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0,
              lat, st, er, rv);
      run_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (rv !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL word0 got %h want a5a5a5a5", rv);
      end
      run_req(1'b1, 1'b0, 32'h2, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rv !== 32'h0) begin
         errors++;
         $display("FAIL err_misalign got %0d/%b/%h want 1/1/0",
                  lat, er, rv);
      end
      checks++;
      if (st[1:0] !== 2'b01) begin
         errors++;
         $display("FAIL err_stall got %b want 01", st[1:0]);
      end
      run_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rv !== 32'h0) begin
         errors++;
         $display("FAIL err_range got %0d/%b/%h want 1/1/0",
                  lat, er, rv);
      end
      run_req(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 1 || er !== 1'b1) begin
         errors++;
         $display("FAIL err_wrange got %0d/%b want 1/1", lat, er);
      end
      run_req(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rv !== 32'h0) begin
         errors++;
         $display("FAIL err_both got %0d/%b/%h want 1/1/0",
                  lat, er, rv);
      end
      run_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (rv !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL no_wrap got %h want a5a5a5a5", rv);
      end
      run_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (rv !== 32'hDEADBEEF || er !== 1'b0) begin
         errors++;
         $display("FAIL err_nochg got %h/%b want deadbeef/0", rv, er);
      end
      run_req(1'b0, 1'b1, 32'hFFC, 32'h0BADCAFE, 4'hF, 0,
              lat, st, er, rv);
      run_req(1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 3 || er !== 1'b0 || rv !== 32'h0BADCAFE) begin
         errors++;
         $display("FAIL top_addr got %0d/%b/%h want 3/0/0badcafe",
                  lat, er, rv);
      end
   endtask

   task automatic test_no_wait;
      logic [5:0] pat;
      logic [31:0] rv;
      wr0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h12345678; be0 = 4'hF;
      #1;
      checks++;
      if (Stall0 !== 1'b1 || MemReady0 !== 1'b0) begin
         errors++;
         $display("FAIL nw_c0 got %b%b want 10", Stall0, MemReady0);
      end
      @(negedge clock);
      checks++;
      if (MemReady0 !== 1'b1 || MemError0 !== 1'b0) begin
         errors++;
         $display("FAIL nw_wr got %b%b want 10", MemReady0, MemError0);
      end
      wr0 = 1'b0;
      @(negedge clock);
      rd0 = 1'b1;
      rv = '0;
      #1;
      pat[0] = MemReady0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         pat[k] = MemReady0;
         if (k == 1) rv = ReadData0;
      end
      rd0 = 1'b0;
      checks++;
      if (pat !== 6'b101010) begin
         errors++;
         $display("FAIL nw_pulses got %b want 101010", pat);
      end
      checks++;
      if (rv !== 32'h12345678) begin
         errors++;
         $display("FAIL nw_data got %h want 12345678", rv);
      end
      @(negedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset_mid_wait;
      int lat; logic [3:0] st; logic er; logic [31:0] rv;
      int seen;
      run_req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0,
              lat, st, er, rv);
      rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h5; be = 4'hF;
      @(negedge clock);
      reset = 1'b0;
      wr = 1'b0;
      #1;
      checks++;
      if ({ReadData, MemReady, MemError, Stall} !== 35'd0) begin
         errors++;
         $display("FAIL rst_outs got %h want 0",
                  {ReadData, MemReady, MemError, Stall});
      end
      checks++;
      if (ReadData0 !== 32'd0) begin
         errors++;
         $display("FAIL rst_outs0 got %h want 0", ReadData0);
      end
      @(negedge clock);
      reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (MemReady) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL rst_noready got %0d want 0", seen);
      end
      run_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0,
              lat, st, er, rv);
      checks++;
      if (lat !== 3 || rv !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL rst_drop got %0d/%h want 3/cafef00d", lat, rv);
      end
   endtask

   task automatic test_drop;
      int lat; logic [3:0] st; logic er; logic [31:0] rv;
      run_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1,
              lat, st, er, rv);
      checks++;
      if (lat !== 3 || er !== 1'b0 || rv !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL drop_resp got %0d/%b/%h want 3/0/deadbeef",
                  lat, er, rv);
      end
      checks++;
      if (st !== 4'b0001) begin
         errors++;
         $display("FAIL drop_stall got %b want 0001", st);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_merge();
      test_errors();
      test_no_wait();
      test_reset_mid_wait();
      test_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined 32-bit CPU: the slave end of the MemRead/MemWrite request interface driven by the datapath's MEM stage. It latches one request at a time, inserts a configurable number of wait states, performs a word read or byte-enabled write on an internal array, and returns a one-cycle MemReady pulse with ReadData and an error flag. While a request is outstanding it raises Stall so the pipeline freezes the MEM stage and everything upstream of it.

## Interface
- ADDR_WIDTH, 10: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2: wait states inserted before a valid access completes; legal range 0..15.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request from MEM stage.
- MemWrite  in  1  write request from MEM stage.
- Addr  in  32  byte address.
- WriteData  in  32  write data.
- ByteEn  in  4  write byte enables; bit i selects bits [8i+7:8i].
- ReadData  out  32  registered read data.
- MemReady  out  1  one-cycle completion pulse.
- MemError  out  1  error qualifier, valid only with MemReady.
- Stall  out  1  pipeline hold request.

## Operation
- FSM states are IDLE, WAIT and RESP. The wait counter is 4 bits wide.
- **IDLE**
  - A request is present when MemRead or MemWrite is high.
  - On the edge, the responder latches the kind, Addr, WriteData and ByteEn. Inputs are ignored until the FSM returns to IDLE.
- **Error checks**, evaluated on the latched request:
  - MemRead and MemWrite both high.
  - Addr[1:0] not equal to 0.
  - Addr[31:ADDR_WIDTH+2] not equal to 0.
- **Transitions out of IDLE**
  - Error, or WAIT_CYCLES equal to 0: the FSM goes directly to RESP, and any valid access is performed on the same edge.
  - Otherwise: the FSM goes to WAIT and loads the counter with WAIT_CYCLES-1.
- **WAIT**
  - Counter not 0: decrement.
  - Counter equal to 0: perform the access and go to RESP.
- **Access**
  - The word index is Addr[ADDR_WIDTH+1:2].
  - Read: ReadData receives the full word. ByteEn is ignored.
  - Write: bytes with ByteEn bit set are merged into the word. ReadData is unchanged. A write with ByteEn equal to 0 changes nothing and still completes normally.
- **Error access**
  - No array change.
  - ReadData is set to 0 and MemError is set to 1.
- **RESP**
  - MemReady=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
  - MemError is 0 on a good response.
- **Data hold**: ReadData holds its value until the next completed read or error.
- **Stall**
  - Combinational: Stall = (MemRead | MemWrite) & ~MemReady.
  - Stall is high in IDLE (with a request pending) and throughout WAIT. It is low in RESP, so the pipeline advances on the RESP edge.

## Timing
- **Reset values**
  - state=IDLE, counter=0.
  - ReadData=0, MemReady=0, MemError=0.
  - Array contents are not cleared.
- **Reset mid-operation**
  - The FSM returns to IDLE immediately.
  - A write not yet performed is dropped.
  - No MemReady is produced for the aborted request.
- **Latency**
  - The request is first seen in IDLE, in cycle 0.
  - A valid request gets MemReady in cycle WAIT_CYCLES+1.
  - An error request always gets MemReady in cycle 1.
- **Throughput**
  - The earliest next acceptance is the IDLE cycle after RESP.
  - Back-to-back requests are therefore spaced WAIT_CYCLES+2 cycles apart.
- **Request hold rule**
  - The requester holds MemRead/MemWrite until MemReady.
  - Deasserting a request after acceptance does not cancel it; the response still occurs.
- **Read-after-write** to the same word returns the merged write data, because the array update precedes the next acceptance.
- **Address range**: the address at index 2^ADDR_WIDTH-1 (byte address 4*(2^ADDR_WIDTH)-4) is valid. 4*2^ADDR_WIDTH is out of range and returns MemError; it never wraps to word 0.

## Test plan
- **Write then read, WAIT_CYCLES=2**
  - Stimulus: write 0xDEADBEEF to Addr 0x10 with ByteEn=4'hF, then read 0x10.
  - Required: each MemReady occurs in cycle 3 after its request. ReadData=0xDEADBEEF. Stall is high for cycles 0-2.
- **Byte merge**
  - Stimulus: word 0x11223344, then a write of 0xAABBCCDD with ByteEn=4'b0101, then a read.
  - Required: ReadData=0x11BB33DD.
- **Error cases**
  - Stimulus, one at a time: Addr=0x2 read; Addr=0x1000 read with ADDR_WIDTH=10; MemRead and MemWrite both high.
  - Required: MemReady and MemError in cycle 1, ReadData=0, array unchanged. Top valid address 0xFFC reads normally.
- **WAIT_CYCLES=0**
  - Stimulus: read held continuously across two requests.
  - Required: MemReady in cycle 1. The second acceptance is in cycle 2. MemReady pulses are 2 cycles apart.
- **Reset mid-WAIT**
  - Stimulus: write 0x5 to 0x20, with reset low during the WAIT state.
  - Required: no MemReady. A read of 0x20 after reset returns the prior contents. All outputs are 0 during reset.
- **Request dropped after acceptance**
  - Stimulus: MemRead deasserted in cycle 1.
  - Required: MemReady still in cycle WAIT_CYCLES+1 with valid data. Stall is low once MemRead drops.
